// File: rtl/cp0_reg_pkg.sv
// cp0_reg_pkg: shared constants for the CP0 register file.
// Holds committed excepttype codes, CP0 register numbers, Status/Cause
// field positions and write masks, plus the ExcCode mapping helper.
package cp0_reg_pkg;

  // Committed excepttype codes from the WB stage
  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h10;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  // CP0 register numbers (all at select 0)
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  // Status / Cause field positions
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;
  localparam int CAUSE_IP7  = 15;

  // Software-writable bits: Status IM[15:8], EXL, IE; Cause IP1..0
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  // Identification registers (visible only with CP0_IDREGS_EN)
  localparam logic [31:0] PRID_VALUE   = 32'h0001_8000;
  localparam logic [31:0] CONFIG_VALUE = 32'h8000_0000;

  // Interrupts report ExcCode 0; every other code passes through
  function automatic logic [4:0] map_exccode(input logic [4:0] et);
    return (et == EXC_INT) ? 5'd0 : et;
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// cp0_reg_if: MTC0/MFC0, exception-commit and register-state signals
// between the pipeline (master) and the CP0 register file (slave).
interface cp0_reg_if;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [2:0]  cp0_wsel;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [2:0]  cp0_rsel;
  logic [31:0] cp0_rdata;
  logic [4:0]  excepttype;
  logic [31:0] exc_pc;
  logic        is_in_delayslot;
  logic [31:0] badvaddr_in;
  logic [5:0]  ext_int;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_badvaddr;
  logic        timer_int;

  modport master (
    output cp0_we, cp0_waddr, cp0_wsel, cp0_wdata, cp0_raddr, cp0_rsel,
           excepttype, exc_pc, is_in_delayslot, badvaddr_in, ext_int,
    input  cp0_rdata, cp0_status, cp0_cause, cp0_epc, cp0_badvaddr, timer_int
  );

  modport slave (
    input  cp0_we, cp0_waddr, cp0_wsel, cp0_wdata, cp0_raddr, cp0_rsel,
           excepttype, exc_pc, is_in_delayslot, badvaddr_in, ext_int,
    output cp0_rdata, cp0_status, cp0_cause, cp0_epc, cp0_badvaddr, timer_int
  );
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with a COUNT_DIV prescaler (1 or 2).
// TI is sticky; a Compare write clears it and wins over a same-cycle match,
// a Count write wins over the same-cycle increment and restarts the prescaler.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        div_cnt;
  logic        div_wrap;
  logic [31:0] count_next;

  // Prescaler wrap and the Count value the match is taken against
  always_comb begin
    div_wrap   = (COUNT_DIV == 1) ? 1'b1 : div_cnt;
    count_next = count;
    if (count_we)
      count_next = wdata;
    else if (div_wrap)
      count_next = count + 32'd1;
  end

  // Timer state update; match compares the post-update Count
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= 1'b0;
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      if (count_we || div_wrap)
        div_cnt <= 1'b0;
      else
        div_cnt <= 1'b1;
      count <= count_next;
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count_next == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC).
// Takes MTC0 writes and exception/ERET commits; commit effects on EXL, EPC,
// Cause and BadVAddr win over a same-cycle MTC0, other written bits still land.
// Optional macro CP0_IDREGS_EN makes PRId (15,0) and Config (16,0) readable.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic      clk,
  input  logic      rst,
  cp0_reg_if.slave  bus
);

  logic [31:0] status, status_next;
  logic [31:0] epc, epc_next;
  logic [31:0] badvaddr, badvaddr_next;
  logic        cause_bd, cause_bd_next;
  logic [4:0]  cause_exc, cause_exc_next;
  logic [1:0]  ip_sw, ip_sw_next;
  logic [5:0]  ip_hw;
  logic [31:0] count, compare;
  logic        ti;
  logic [31:0] cause;

  logic wr_sel0, wr_status, wr_cause, wr_epc, wr_count, wr_compare;
  logic exc_commit, eret_commit;

  // Write-port decode and commit classification
  always_comb begin
    wr_sel0     = bus.cp0_we && (bus.cp0_wsel == 3'd0);
    wr_status   = wr_sel0 && (bus.cp0_waddr == CP0_STATUS);
    wr_cause    = wr_sel0 && (bus.cp0_waddr == CP0_CAUSE);
    wr_epc      = wr_sel0 && (bus.cp0_waddr == CP0_EPC);
    wr_count    = wr_sel0 && (bus.cp0_waddr == CP0_COUNT);
    wr_compare  = wr_sel0 && (bus.cp0_waddr == CP0_COMPARE);
    exc_commit  = (bus.excepttype != EXC_NONE) && (bus.excepttype != EXC_ERET);
    eret_commit = (bus.excepttype == EXC_ERET);
  end

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (bus.cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Next-state: MTC0 first, then the commit overrides its own fields
  always_comb begin
    status_next    = status;
    epc_next       = epc;
    badvaddr_next  = badvaddr;
    cause_bd_next  = cause_bd;
    cause_exc_next = cause_exc;
    ip_sw_next     = ip_sw;

    if (wr_status)
      status_next = (status & ~STATUS_WMASK) | (bus.cp0_wdata & STATUS_WMASK);
    if (wr_cause)
      ip_sw_next = bus.cp0_wdata[9:8];
    if (wr_epc)
      epc_next = bus.cp0_wdata;

    if (exc_commit) begin
      // A nested exception (EXL already set) keeps the original EPC/BD
      if (!status[STATUS_EXL]) begin
        epc_next      = bus.is_in_delayslot ? bus.exc_pc - 32'd4 : bus.exc_pc;
        cause_bd_next = bus.is_in_delayslot;
      end
      status_next[STATUS_EXL] = 1'b1;
      cause_exc_next          = map_exccode(bus.excepttype);
      if (bus.excepttype == EXC_ADEL || bus.excepttype == EXC_ADES)
        badvaddr_next = bus.badvaddr_in;
    end else if (eret_commit) begin
      status_next[STATUS_EXL] = 1'b0;
    end
  end

  // Register update; reset overrides any pending write or commit
  always_ff @(posedge clk) begin
    if (!rst) begin
      status    <= RESET_STATUS;
      epc       <= 32'd0;
      badvaddr  <= 32'd0;
      cause_bd  <= 1'b0;
      cause_exc <= 5'd0;
      ip_sw     <= 2'd0;
      ip_hw     <= 6'd0;
    end else begin
      status    <= status_next;
      epc       <= epc_next;
      badvaddr  <= badvaddr_next;
      cause_bd  <= cause_bd_next;
      cause_exc <= cause_exc_next;
      ip_sw     <= ip_sw_next;
      ip_hw     <= bus.ext_int;
    end
  end

  // Cause assembly; IP7 folds in TI so it tracks the timer in the same cycle
  always_comb begin
    cause                      = 32'd0;
    cause[CAUSE_BD]            = cause_bd;
    cause[CAUSE_TI]            = ti;
    cause[CAUSE_IP7]           = ip_hw[5] | ti;
    cause[CAUSE_IP7-1:10]      = ip_hw[4:0];
    cause[9:8]                 = ip_sw;
    cause[6:2]                 = cause_exc;
  end

  // MFC0 read mux from current state (no write bypass)
  always_comb begin
    bus.cp0_rdata = 32'd0;
    if (bus.cp0_rsel == 3'd0) begin
      case (bus.cp0_raddr)
        CP0_BADVADDR: bus.cp0_rdata = badvaddr;
        CP0_COUNT:    bus.cp0_rdata = count;
        CP0_COMPARE:  bus.cp0_rdata = compare;
        CP0_STATUS:   bus.cp0_rdata = status;
        CP0_CAUSE:    bus.cp0_rdata = cause;
        CP0_EPC:      bus.cp0_rdata = epc;
`ifdef CP0_IDREGS_EN
        CP0_PRID:     bus.cp0_rdata = PRID_VALUE;
        CP0_CONFIG:   bus.cp0_rdata = CONFIG_VALUE;
`else
        CP0_PRID:     bus.cp0_rdata = 32'd0;
        CP0_CONFIG:   bus.cp0_rdata = 32'd0;
`endif
        default:      bus.cp0_rdata = 32'd0;
      endcase
    end
  end

  assign bus.cp0_status   = status;
  assign bus.cp0_cause    = cause;
  assign bus.cp0_epc      = epc;
  assign bus.cp0_badvaddr = badvaddr;
  assign bus.timer_int    = ti;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed plus randomized stimulus against a behavioural
// register-file model; every cycle the full visible state is compared.
module tb_cp0_reg;

  localparam int          COUNT_DIV    = 2;
  localparam logic [31:0] RESET_STATUS = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cp0_reg_if bus ();

  cp0_reg #(.COUNT_DIV(COUNT_DIV), .RESET_STATUS(RESET_STATUS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_status, m_epc, m_bad, m_count, m_compare;
  logic        m_bd, m_ti;
  logic [4:0]  m_exc;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_hw;
  int          m_phase;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_hw[5] | m_ti, m_hw[4:0], m_ipsw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s != 3'd0) return 32'd0;
    case (a)
      5'd8:  return m_bad;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause();
      5'd14: return m_epc;
`ifdef CP0_IDREGS_EN
      5'd15: return 32'h0001_8000;
      5'd16: return 32'h8000_0000;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock of architectural behaviour, from the inputs present now
  task automatic model_step();
    logic       wr, exc, eret, old_exl;
    logic [4:0] et;
    if (!rst) begin
      m_status = RESET_STATUS; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0;
      m_bd = 0; m_ti = 0; m_exc = 0; m_ipsw = 0; m_hw = 0; m_phase = 0;
      return;
    end
    wr   = bus.cp0_we && bus.cp0_wsel == 3'd0;
    et   = bus.excepttype;
    exc  = (et != 5'h00) && (et != 5'h0e);
    eret = (et == 5'h0e);
    old_exl = m_status[1];
    if (wr && bus.cp0_waddr == 5'd9) begin
      m_count = bus.cp0_wdata; m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
      if (m_phase == COUNT_DIV) begin m_phase = 0; m_count = m_count + 32'd1; end
    end
    if (wr && bus.cp0_waddr == 5'd11) begin m_compare = bus.cp0_wdata; m_ti = 0; end
    else if (m_count == m_compare) m_ti = 1;
    m_hw = bus.ext_int;
    if (wr && bus.cp0_waddr == 5'd12)
      m_status = {m_status[31:16], bus.cp0_wdata[15:8], m_status[7:2], bus.cp0_wdata[1:0]};
    if (wr && bus.cp0_waddr == 5'd13) m_ipsw = bus.cp0_wdata[9:8];
    if (wr && bus.cp0_waddr == 5'd14) m_epc = bus.cp0_wdata;
    if (exc) begin
      if (!old_exl) begin
        m_epc = bus.is_in_delayslot ? bus.exc_pc - 32'd4 : bus.exc_pc;
        m_bd  = bus.is_in_delayslot;
      end
      m_status[1] = 1'b1;
      m_exc = (et == 5'h10) ? 5'd0 : et;
      if (et == 5'h04 || et == 5'h05) m_bad = bus.badvaddr_in;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    chk("status",   bus.cp0_status,   m_status);
    chk("cause",    bus.cp0_cause,    m_cause());
    chk("epc",      bus.cp0_epc,      m_epc);
    chk("badvaddr", bus.cp0_badvaddr, m_bad);
    chk("timer_int", {31'd0, bus.timer_int}, {31'd0, m_ti});
    chk("rdata",    bus.cp0_rdata,    m_read(bus.cp0_raddr, bus.cp0_rsel));
  endtask

  task automatic clear_inputs();
    bus.cp0_we = 0; bus.cp0_waddr = 0; bus.cp0_wsel = 0; bus.cp0_wdata = 0;
    bus.excepttype = 0; bus.exc_pc = 0; bus.is_in_delayslot = 0; bus.badvaddr_in = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we = 1; bus.cp0_waddr = a; bus.cp0_wsel = 0; bus.cp0_wdata = d;
    step();
    clear_inputs();
  endtask

  task automatic commit(input logic [4:0] et, input logic [31:0] pc, input logic ds,
                        input logic [31:0] bad);
    bus.excepttype = et; bus.exc_pc = pc; bus.is_in_delayslot = ds; bus.badvaddr_in = bad;
    step();
    clear_inputs();
  endtask

  logic [4:0] rd_addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
  logic [4:0] exc_codes [9] = '{5'h10, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c, 5'h0e, 5'h04};

  initial begin
    int n;
    clear_inputs();
    bus.cp0_raddr = 5'd12; bus.cp0_rsel = 0; bus.ext_int = 0;

    // Reset for two cycles
    rst = 0;
    step(); step();
    chk("rst_status", bus.cp0_status, 32'h0040_0000);
    chk("rst_cause",  bus.cp0_cause,  32'd0);
    chk("rst_epc",    bus.cp0_epc,    32'd0);
    chk("rst_ti",     {31'd0, bus.timer_int}, 32'd0);
    rst = 1;

    // Park Compare far away before Count==Compare can match at 0
    mtc0(5'd11, 32'h8000_0000);
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk("status_mask", bus.cp0_status, 32'h0040_FF03);
    bus.cp0_raddr = 5'd13;
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("cause_mask", bus.cp0_cause, 32'h0000_0300);

    // Timer: Compare=10, Count=0, expect TI about 20 cycles later
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    n = 0;
    while (!bus.timer_int && n < 40) begin step(); n++; end
    chk("ti_latency_in_range", {31'd0, (n >= 20 && n <= 21)}, 32'd1);
    chk("ti_cause30", {31'd0, bus.cp0_cause[30]}, 32'd1);
    chk("ti_cause15", {31'd0, bus.cp0_cause[15]}, 32'd1);
    chk("ti_out",     {31'd0, bus.timer_int},     32'd1);
    step();
    chk("ti_sticky",  {31'd0, bus.timer_int},     32'd1);
    mtc0(5'd11, 32'h8000_0000);
    chk("ti_clr_cause30", {31'd0, bus.cp0_cause[30]}, 32'd0);
    chk("ti_clr_cause15", {31'd0, bus.cp0_cause[15]}, 32'd0);
    chk("ti_clr_out",     {31'd0, bus.timer_int},     32'd0);

    // Count wrap
    bus.cp0_raddr = 5'd9;
    mtc0(5'd9, 32'hFFFF_FFFF);
    chk("count_wr", bus.cp0_rdata, 32'hFFFF_FFFF);
    step(); step();
    chk("count_wrap", bus.cp0_rdata, 32'd0);

    // Hardware interrupt sampling
    bus.ext_int = 6'b100101;
    step();
    chk("ext_int_ip", {26'd0, bus.cp0_cause[15:10]}, 32'b100101);
    bus.ext_int = 0;

    // Exceptions: clear EXL first, then ADEL in a delay slot
    mtc0(5'd12, 32'h0000_FF01);
    bus.cp0_raddr = 5'd14;
    commit(5'h04, 32'hbfc0_1000, 1'b1, 32'h1);
    chk("adel_epc",  bus.cp0_epc, 32'hbfc0_0ffc);
    chk("adel_bd",   {31'd0, bus.cp0_cause[31]}, 32'd1);
    chk("adel_code", {27'd0, bus.cp0_cause[6:2]}, 32'd4);
    chk("adel_bad",  bus.cp0_badvaddr, 32'h1);
    chk("adel_exl",  {31'd0, bus.cp0_status[1]}, 32'd1);
    commit(5'h08, 32'hbfc0_2000, 1'b0, 32'h0);
    chk("nested_epc", bus.cp0_epc, 32'hbfc0_0ffc);
    commit(5'h0e, 32'h0, 1'b0, 32'h0);
    chk("eret_exl", {31'd0, bus.cp0_status[1]}, 32'd0);

    // Commit and MTC0 EPC in the same cycle
    bus.cp0_we = 1; bus.cp0_waddr = 5'd14; bus.cp0_wdata = 32'h1234;
    commit(5'h08, 32'hbfc0_3000, 1'b0, 32'h0);
    chk("coll_epc",  bus.cp0_epc, 32'hbfc0_3000);
    chk("coll_code", {27'd0, bus.cp0_cause[6:2]}, 32'd8);

    // Identification registers
    bus.cp0_raddr = 5'd15;
    mtc0(5'd15, 32'hDEAD_BEEF);
`ifdef CP0_IDREGS_EN
    chk("prid", bus.cp0_rdata, 32'h0001_8000);
`else
    chk("prid", bus.cp0_rdata, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bus.ext_int   = 6'($urandom);
      bus.cp0_raddr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : rd_addrs[$urandom_range(0, 7)];
      bus.cp0_rsel  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
      if ($urandom_range(0, 2) == 0) begin
        bus.cp0_we    = 1;
        bus.cp0_waddr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : rd_addrs[$urandom_range(0, 7)];
        bus.cp0_wsel  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
        bus.cp0_wdata = $urandom;
        if (bus.cp0_waddr == 5'd11 && $urandom_range(0, 1) == 0)
          bus.cp0_wdata = m_count + 32'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 5) == 0) begin
        bus.excepttype      = exc_codes[$urandom_range(0, 8)];
        bus.exc_pc          = $urandom & 32'hFFFF_FFFC;
        bus.is_in_delayslot = 1'($urandom);
        bus.badvaddr_in     = $urandom;
      end
      if (i == 250) rst = 0;
      step();
      if (i == 250) begin
        chk("midrst_status", bus.cp0_status, 32'h0040_0000);
        rst = 1;
      end
      clear_inputs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file: the write/commit end of the CP0 interface that the MEM stage reads.
- Accepts MTC0 writes and exception/ERET commits from the WB side.
- Runs the Count/Compare timer and latches hardware interrupt lines.
- Drives Status/Cause/EPC/BadVAddr/timer_int back to MEM, and read data to the MFC0 path in EX.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (legal values 1 or 2).
- RESET_STATUS, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low (rst==0 resets on posedge clk)
- cp0_we  input  1  MTC0 write enable
- cp0_waddr  input  5  write register number
- cp0_wsel  input  3  write select
- cp0_wdata  input  32  write data
- cp0_raddr  input  5  MFC0 register number
- cp0_rsel  input  3  MFC0 select
- cp0_rdata  output  32  MFC0 read data (combinational from state)
- excepttype  input  5  committed exception code, 0 = none
- exc_pc  input  32  PC of excepting instruction
- is_in_delayslot  input  1  excepting instruction is in a delay slot
- badvaddr_in  input  32  faulting address
- ext_int  input  6  hardware interrupt lines
- cp0_status, cp0_cause, cp0_epc, cp0_badvaddr  output  32 each  register state
- timer_int  output  1  equals Cause.TI

Behaviour:
- Registers, all sel 0: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
- Other addresses/sels read 0; writes to them are ignored.
- Reset: Status=RESET_STATUS; Cause, Count, Compare, EPC and BadVAddr = 0; timer_int=0; divider phase=0.
- Write masks:
  - Status: only [15:8] IM, [1] EXL, [0] IE are writable; BEV [22] is read-only 1.
  - Cause: only [9:8] IP1..0 are writable.
  - BadVAddr is read-only.
  - Count, Compare and EPC are fully writable.
- Writes take effect at the next posedge. cp0_rdata shows pre-write state (no same-cycle bypass).
- Cause[15:10] is re-sampled every cycle as {ext_int[5] | TI, ext_int[4:0]}.
- Timer:
  - Divider counter increments each cycle; Count += 1 when it wraps; Count wraps 32'hFFFF_FFFF -> 0.
  - The cycle Count==Compare (after update) sets TI (Cause[30]). TI is sticky.
  - Any Compare write clears TI and overrides the same-cycle match.
  - A Count write overrides the same-cycle increment and resets the divider phase.
- Exception commit (excepttype nonzero, not ERET):
  - If Status.EXL==0: EPC = is_in_delayslot ? exc_pc-4 : exc_pc; Cause.BD[31] = is_in_delayslot.
  - If EXL was already 1: EPC and BD are unchanged.
  - Always: EXL=1; Cause.ExcCode[6:2] = mapped code.
  - For ADEL/ADES: BadVAddr = badvaddr_in.
- ERET commit: EXL=0; nothing else changes.
- Simultaneous commit and cp0_we: the commit's effects on EXL/EPC/Cause/BadVAddr win. Non-conflicting bits of the MTC0 write still apply.
- excepttype is asserted exactly one cycle per exception by WB. A repeated nonzero value is treated as a new commit.
- Reset mid-operation overrides everything, including a pending commit or write.

Optional Feature:
- Macro: CP0_IDREGS_EN.
- Defined: read-only PRId(15,0)=32'h0001_8000 and Config(16,0)=32'h8000_0000 are readable.
- Undefined: both read 0. Writes are always ignored.

Decomposition:
- defines.vh holds:
  - internal excepttype codes: EXC_INT=5'h10, EXC_ADEL=5'h04, EXC_ADES=5'h05, EXC_SYS=5'h08, EXC_BP=5'h09, EXC_RI=5'h0a, EXC_OV=5'h0c, EXC_ERET=5'h0e;
  - CP0 register-number constants;
  - Status/Cause field bit positions.
- ExcCode mapping: INT->0; all others pass their low 5 bits through.
- One sub-module, cp0_timer: divider, Count, Compare, TI, with write ports and match logic.

Test Plan:
- Reset with rst=0 for 2 cycles -> status=32'h0040_0000, cause=0, epc=0, timer_int=0.
- MTC0 Status 32'hFFFF_FFFF -> status=32'h0040_FF03. MTC0 Cause 32'hFFFF_FFFF -> cause[9:8]=2'b11 and all other writable-masked bits unchanged.
- Compare=10, Count=0, COUNT_DIV=2:
  - TI sets 20-21 cycles after the writes, and cause[30], cause[15] and timer_int are all 1.
  - A subsequent Compare write clears all three the next cycle.
- excepttype=EXC_ADEL, exc_pc=32'hbfc0_1000, delayslot=1, badvaddr_in=32'h1 -> epc=32'hbfc0_0ffc, cause[31]=1, cause[6:2]=4, badvaddr=1, status[1]=1.
- Second exception with EXL=1 at pc 32'hbfc0_2000 -> epc unchanged. Then EXC_ERET -> status[1]=0.
- Same cycle: EXC_SYS commit plus MTC0 EPC=32'h1234 -> epc=exc_pc and ExcCode=8.
